gpio_status_sequencer: RTL

//  Owns the status-LED GPIO pad bank between the SoC GPIO controller and the bidirectional pad buffers.
//  - While the SoC is held in reset: drives a walking-one boot pattern.
//  - After SoC reset releases: drives all pins low for a handoff window, then passes SoC GPIO through.
//  - Optional: latches a sticky fault blink pattern.
//  - Sits in the board top between the SoC gpioStatus pins and the pad tristate buffers.

---
 rtl/gpio_status_pkg.sv | 21 ++
 rtl/gpio_status_timer.sv | 27 ++
 rtl/gpio_status_sequencer.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/gpio_status_pkg.sv
// Shared definitions for the status-LED GPIO sequencer: state encoding,
// state width, default pin count and a small constant helper.
package gpio_status_pkg;

    localparam int STATE_W    = 2;
    localparam int PIN_NO_DEF = 4;

    typedef enum logic [STATE_W-1:0] {
        WALK    = 2'd0,
        HANDOFF = 2'd1,
        SOC     = 2'd2,
        FAULT   = 2'd3
    } state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/gpio_status_timer.sv
// Prescale counter: counts up from zero, pulses o_tick for one cycle when the
// count equals i_term, then restarts from zero. i_clear restarts it at once.
module gpio_status_timer #(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_clear,
    input  logic [W-1:0] i_term,
    output logic         o_tick
);

    logic [W-1:0] r_count;

    assign o_tick = (r_count == i_term);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_clear || o_tick) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + W'(1);
        end
    end

endmodule

// File: rtl/gpio_status_sequencer.sv
// Status-LED pad owner: walking-one boot pattern, low handoff window, then SoC
// pass-through. Define GPIO_STATUS_FAULT_EN to add the sticky FAULT blink state.
module gpio_status_sequencer
    import gpio_status_pkg::*;
#(
    parameter int PIN_NO         = PIN_NO_DEF,
    parameter int STEP_CYCLES    = 25000000,
    parameter int HANDOFF_CYCLES = 1024,
    parameter int BLINK_CYCLES   = 12500000
) (
    input  logic               io_clock,
    input  logic               io_reset,
    input  logic               io_sysReset_in,
    input  logic               io_fault,
    input  logic [PIN_NO-1:0]  io_soc_write,
    input  logic [PIN_NO-1:0]  io_soc_writeEnable,
    output logic [PIN_NO-1:0]  io_soc_read,
    output logic [PIN_NO-1:0]  io_pins_write,
    output logic [PIN_NO-1:0]  io_pins_writeEnable,
    input  logic [PIN_NO-1:0]  io_pins_read,
    output logic [STATE_W-1:0] io_state
);

    localparam int MAXC = max3(STEP_CYCLES, HANDOFF_CYCLES, BLINK_CYCLES);
    localparam int TW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam logic [TW-1:0] TERM_STEP  = TW'(STEP_CYCLES - 1);
    localparam logic [TW-1:0] TERM_HAND  = TW'(HANDOFF_CYCLES - 1);
    localparam logic [TW-1:0] TERM_BLINK = TW'(BLINK_CYCLES - 1);

    state_t            r_state;
    logic [PIN_NO-1:0] r_pattern;
    logic              r_blink;
    logic [PIN_NO-1:0] r_pins_write;
    logic [PIN_NO-1:0] r_pins_we;
    logic [PIN_NO-1:0] r_sync1;
    logic [PIN_NO-1:0] r_sync2;

    state_t            w_next_state;
    logic [PIN_NO-1:0] w_next_pattern;
    logic              w_next_blink;
    logic [PIN_NO-1:0] w_pins_write_nxt;
    logic [PIN_NO-1:0] w_pins_we_nxt;
    logic [TW-1:0]     w_term;
    logic              w_clear;
    logic              w_tick;

`ifndef GPIO_STATUS_FAULT_EN
    logic w_unused_fault;
    assign w_unused_fault = io_fault;
`endif

    gpio_status_timer #(.W(TW)) u_timer (
        .i_clk   (io_clock),
        .i_rst   (io_reset),
        .i_clear (w_clear),
        .i_term  (w_term),
        .o_tick  (w_tick)
    );

    // Priority on one edge: fault, then SoC reset, then timer expiry.
    always_comb begin
        w_next_state   = r_state;
        w_next_pattern = r_pattern;
        w_next_blink   = r_blink;
        w_term         = TERM_STEP;
        case (r_state)
            WALK: begin
                w_term = TERM_STEP;
                if (!io_sysReset_in) begin
                    w_next_state = HANDOFF;
                end else if (w_tick) begin
                    w_next_pattern = (r_pattern << 1) | (r_pattern >> (PIN_NO - 1));
                end
            end
            HANDOFF: begin
                w_term = TERM_HAND;
                if (io_sysReset_in) begin
                    w_next_state   = WALK;
                    w_next_pattern = PIN_NO'(1);
                end else if (w_tick) begin
                    w_next_state = SOC;
                end
            end
            SOC: begin
                if (io_sysReset_in) begin
                    w_next_state   = WALK;
                    w_next_pattern = PIN_NO'(1);
                end
            end
            FAULT: begin
                w_term = TERM_BLINK;
                if (w_tick) begin
                    w_next_blink = ~r_blink;
                end
            end
        endcase
`ifdef GPIO_STATUS_FAULT_EN
        if (io_fault) begin
            w_next_state = FAULT;
            if (r_state != FAULT) begin
                w_next_blink = 1'b1;
            end
        end
`endif
    end

    // Pad values are computed from the next state so a state change shows on the same edge.
    always_comb begin
        w_pins_we_nxt    = '1;
        w_pins_write_nxt = '0;
        case (w_next_state)
            WALK:    w_pins_write_nxt = w_next_pattern;
            HANDOFF: w_pins_write_nxt = '0;
            SOC: begin
                w_pins_write_nxt = io_soc_write;
                w_pins_we_nxt    = io_soc_writeEnable;
            end
            FAULT:   w_pins_write_nxt = {PIN_NO{w_next_blink}};
        endcase
        w_clear = (w_next_state != r_state) || (r_state == SOC);
    end

    always_ff @(posedge io_clock or posedge io_reset) begin
        if (io_reset) begin
            r_state      <= WALK;
            r_pattern    <= PIN_NO'(1);
            r_blink      <= 1'b1;
            r_pins_write <= '0;
            r_pins_we    <= '0;
            r_sync1      <= '0;
            r_sync2      <= '0;
        end else begin
            r_state      <= w_next_state;
            r_pattern    <= w_next_pattern;
            r_blink      <= w_next_blink;
            r_pins_write <= w_pins_write_nxt;
            r_pins_we    <= w_pins_we_nxt;
            r_sync1      <= io_pins_read;
            r_sync2      <= r_sync1;
        end
    end

    assign io_pins_write       = r_pins_write;
    assign io_pins_writeEnable = r_pins_we;
    assign io_soc_read         = r_sync2;
    assign io_state            = r_state;

endmodule
